// File: rtl/sync_count_reg_pkg.sv
// Shared constants and helpers for the sync_count_reg counter slice.
package sync_count_reg_pkg;

  localparam int unsigned COUNT_DEFAULT_WIDTH = 32'd3;

  // Returns a 32-bit value with the low `width` bits set (width >= 32 gives all ones).
  function automatic logic [31:0] all_ones(input int unsigned width);
    logic [31:0] w_mask;
    if (width >= 32'd32) begin
      w_mask = 32'hFFFF_FFFF;
    end else begin
      w_mask = (32'd1 << width) - 32'd1;
    end
    return w_mask;
  endfunction

endpackage

// File: rtl/sync_count_reg_if.sv
// Control/status bundle between a counter user (master) and sync_count_reg (slave).
interface sync_count_reg_if #(
  parameter int unsigned WIDTH = sync_count_reg_pkg::COUNT_DEFAULT_WIDTH
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] count_load;
  logic [WIDTH-1:0] count;
  logic             tc;

  modport master (
    output en, load, count_load,
    input  count, tc
  );

  modport slave (
    input  en, load, count_load,
    output count, tc
  );
endinterface

// File: rtl/sync_count_reg_d_reg_sync.sv
// Generic enable-gated D register with synchronous active-high reset to zero.
module d_reg_sync #(
  parameter int unsigned WIDTH = 32'd3
) (
  input  logic             clk,
  input  logic             en,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Reset dominates enable; otherwise load d when enabled, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/sync_count_reg.sv
// Up-counter with load/enable/synchronous reset and combinational terminal count.
// Define COUNT_REG_SATURATE_EN to hold at all-ones instead of wrapping.
module sync_count_reg
  import sync_count_reg_pkg::*;
#(
  parameter int unsigned WIDTH       = COUNT_DEFAULT_WIDTH,
  parameter int unsigned RESET_VALUE = 32'd0
) (
  input  logic clk,
  input  logic rst,
  sync_count_reg_if.slave bus
);

  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_next_count;
  logic [WIDTH-1:0] w_reg_d;
  logic [WIDTH-1:0] w_reg_q;
  logic             w_reg_en;
  logic             w_at_max;

  // The shared register clears to zero, so the count is stored XORed with
  // RST_VAL: a cleared register then reads back as RESET_VALUE.
  assign w_count  = w_reg_q ^ RST_VAL;
  assign w_at_max = (32'(w_count) == all_ones(WIDTH));
  assign w_reg_en = rst | bus.load | bus.en;
  assign w_reg_d  = w_next_count ^ RST_VAL;

  // Next-count selection: reset, then load, then increment, then hold.
  always_comb begin
    w_next_count = w_count;
    if (rst) begin
      w_next_count = RST_VAL;
    end else if (bus.load) begin
      w_next_count = bus.count_load;
    end else if (bus.en) begin
`ifdef COUNT_REG_SATURATE_EN
      if (w_at_max) begin
        w_next_count = w_count;
      end else begin
        w_next_count = w_count + WIDTH'(1);
      end
`else
      w_next_count = w_count + WIDTH'(1);
`endif
    end else begin
      w_next_count = w_count;
    end
  end

  d_reg_sync #(
    .WIDTH (WIDTH)
  ) u_count_reg (
    .clk   (clk),
    .en    (w_reg_en),
    .reset (rst),
    .d     (w_reg_d),
    .q     (w_reg_q)
  );

  assign bus.count = w_count;
  assign bus.tc    = w_at_max & bus.en & ~bus.load & ~rst;

endmodule

// File: tb/tb_sync_count_reg.sv
// Directed self-checking bench for sync_count_reg (WIDTH=3, RESET_VALUE=0).
module tb_sync_count_reg;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [2:0] e_cnt;

  sync_count_reg_if #(.WIDTH(3)) bus ();

  sync_count_reg #(
    .WIDTH       (3),
    .RESET_VALUE (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    bus.load   = 1'b1;
    bus.en     = 1'b1;
    bus.count_load = 3'd5;

    step();
    check("rst_over_load", 32'(bus.count), 32'd0);
    check("tc_in_rst", 32'(bus.tc), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_held", 32'(bus.count), 32'd0);
    end

    rst      = 1'b0;
    bus.load = 1'b0;
    bus.en   = 1'b1;
    #1;
    check("tc_at_zero", 32'(bus.tc), 32'd0);
    e_cnt = 3'd0;
    for (int i = 0; i < 9; i++) begin
`ifdef COUNT_REG_SATURATE_EN
      e_cnt = (e_cnt == 3'd7) ? 3'd7 : e_cnt + 3'd1;
`else
      e_cnt = e_cnt + 3'd1;
`endif
      step();
      check("count_seq", 32'(bus.count), 32'(e_cnt));
      check("tc_seq", 32'(bus.tc), (e_cnt == 3'd7) ? 32'd1 : 32'd0);
    end

    bus.load = 1'b1;
    bus.en   = 1'b0;
    bus.count_load = 3'd3;
    step();
    check("load_3", 32'(bus.count), 32'd3);
    bus.count_load = 3'd6;
    bus.en   = 1'b1;
    step();
    check("load_over_en", 32'(bus.count), 32'd6);
    bus.load = 1'b0;
    step();
    check("inc_after_load", 32'(bus.count), 32'd7);
    check("tc_at_7", 32'(bus.tc), 32'd1);
    bus.load = 1'b1;
    bus.count_load = 3'd4;
    #1;
    check("tc_masked_by_load", 32'(bus.tc), 32'd0);
    bus.en = 1'b0;
    step();
    check("load_4", 32'(bus.count), 32'd4);

    bus.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold", 32'(bus.count), 32'd4);
      check("tc_hold", 32'(bus.tc), 32'd0);
    end
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step();
    check("rst_glitch", 32'(bus.count), 32'd4);

    bus.load = 1'b1;
    bus.count_load = 3'd5;
    step();
    check("load_5", 32'(bus.count), 32'd5);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    rst      = 1'b1;
    step();
    check("mid_burst_rst", 32'(bus.count), 32'd0);
    rst = 1'b0;
    step();
    check("resume_1", 32'(bus.count), 32'd1);
    step();
    check("resume_2", 32'(bus.count), 32'd2);

    e_cnt = 3'd2;
    for (int i = 0; i < 10; i++) begin
`ifdef COUNT_REG_SATURATE_EN
      e_cnt = (e_cnt == 3'd7) ? 3'd7 : e_cnt + 3'd1;
`else
      e_cnt = e_cnt + 3'd1;
`endif
      step();
      check("long_run", 32'(bus.count), 32'(e_cnt));
    end
`ifdef COUNT_REG_SATURATE_EN
    check("sat_tc", 32'(bus.tc), 32'd1);
`endif
    bus.load = 1'b1;
    bus.count_load = 3'd2;
    step();
    check("load_2", 32'(bus.count), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
